shift_sched: RTL and testbench

- Sequencer/arbiter in front of the shared combinational shift unit (execute_shift).
- Accepts shift requests from two issue ports (port 0: main pipe, port 1: secondary/microcode pipe) and arbitrates between them round-robin.
- Drives the shifter's operand inputs and returns registered results with a requester tag.
- Implements ROL/ROR, which the shifter lacks, as two shifter passes OR-combined.

---
 rtl/shift_sched.sv | 201 ++++++++++++++++++++
 tb/tb_shift_sched.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : shift_sched
// Purpose  : Round-robin sequencer in front of the shared combinational
//            shifter. Takes shift requests from two issue ports, drives the
//            shifter operands, returns registered, tagged results. ROL/ROR
//            are built from two shifter passes whose results are OR-combined.
// Ports    : clk, rst                 - clock, synchronous active-high reset
//            in{0,1}_valid/ready      - per-port request handshake
//            in{0,1}_opecode/data/amt - per-port request payload
//            sh_opecode/data/amt      - operands to the shifter
//            sh_result                - shifter result (same cycle)
//            out_valid/ready          - result handshake
//            out_data/tag/err         - result, originating port, bad-op flag
// Revision : 1.0 - initial release
// ============================================================================
module shift_sched #(
  parameter int LEN_REG     = 32,
  parameter int LEN_OPECODE = 6,
  parameter logic [LEN_OPECODE-1:0] OPECODE_SHL = 'h10,
  parameter logic [LEN_OPECODE-1:0] OPECODE_SHR = 'h11,
  parameter logic [LEN_OPECODE-1:0] OPECODE_ASH = 'h12,
  parameter logic [LEN_OPECODE-1:0] OPECODE_ROL = 'h13,
  parameter logic [LEN_OPECODE-1:0] OPECODE_ROR = 'h14
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in0_valid,
  output logic                   in0_ready,
  input  logic [LEN_OPECODE-1:0] in0_opecode,
  input  logic [LEN_REG-1:0]     in0_data,
  input  logic [4:0]             in0_amt,
  input  logic                   in1_valid,
  output logic                   in1_ready,
  input  logic [LEN_OPECODE-1:0] in1_opecode,
  input  logic [LEN_REG-1:0]     in1_data,
  input  logic [4:0]             in1_amt,
  output logic [LEN_OPECODE-1:0] sh_opecode,
  output logic [LEN_REG-1:0]     sh_data,
  output logic [4:0]             sh_amt,
  input  logic [LEN_REG-1:0]     sh_result,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LEN_REG-1:0]     out_data,
  output logic                   out_tag,
  output logic                   out_err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS1 = 2'd1,
    ST_PASS2 = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic                   rr_q, rr_d;        // 0: port0 wins a tie, 1: port1
  logic [LEN_OPECODE-1:0] op_q, op_d;
  logic [LEN_REG-1:0]     data_q, data_d;
  logic [4:0]             amt_q, amt_d;
  logic                   tag_q, tag_d;
  logic [LEN_REG-1:0]     partial_q, partial_d;
  logic                   out_valid_q, out_valid_d;
  logic [LEN_REG-1:0]     out_data_q, out_data_d;
  logic                   out_tag_q, out_tag_d;
  logic                   out_err_q, out_err_d;

  logic                   w_slot_ok;
  logic                   w_grant;
  logic                   w_pick1;
  logic                   w_native;
  logic                   w_is_rol;
  logic                   w_is_ror;
  logic [LEN_OPECODE-1:0] w_sh_opecode;
  logic [LEN_REG-1:0]     w_sh_data;
  logic [4:0]             w_sh_amt;

  // Accept only with nothing in flight and the result slot free or draining.
  assign w_slot_ok = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign w_pick1   = in1_valid && (!in0_valid || rr_q);
  assign w_grant   = w_slot_ok && (in0_valid || in1_valid);

  assign w_native  = (op_q == OPECODE_SHL) || (op_q == OPECODE_SHR) ||
                     (op_q == OPECODE_ASH);
  assign w_is_rol  = (op_q == OPECODE_ROL);
  assign w_is_ror  = (op_q == OPECODE_ROR);

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    op_d         = op_q;
    data_d       = data_q;
    amt_d        = amt_q;
    tag_d        = tag_q;
    partial_d    = partial_q;
    out_valid_d  = out_valid_q && !out_ready;
    out_data_d   = out_data_q;
    out_tag_d    = out_tag_q;
    out_err_d    = out_err_q;
    w_sh_opecode = '0;
    w_sh_data    = '0;
    w_sh_amt     = '0;

    case (state_q)
      ST_IDLE: begin
        if (w_grant) begin
          op_d    = w_pick1 ? in1_opecode : in0_opecode;
          data_d  = w_pick1 ? in1_data    : in0_data;
          amt_d   = w_pick1 ? in1_amt     : in0_amt;
          tag_d   = w_pick1;
          rr_d    = !w_pick1;              // the other port gets the next tie
          state_d = ST_PASS1;
        end
      end

      ST_PASS1: begin
        if (w_native) begin
          w_sh_opecode = op_q;
          w_sh_data    = data_q;
          w_sh_amt     = amt_q;
          out_valid_d  = 1'b1;
          out_data_d   = sh_result;
          out_tag_d    = tag_q;
          out_err_d    = 1'b0;
          state_d      = ST_IDLE;
        end else if (w_is_rol || w_is_ror) begin
          // First half of the rotate: the bits that stay in-word.
          w_sh_opecode = w_is_rol ? OPECODE_SHL : OPECODE_SHR;
          w_sh_data    = data_q;
          w_sh_amt     = amt_q;
          partial_d    = sh_result;
          state_d      = ST_PASS2;
        end else begin
          out_valid_d  = 1'b1;
          out_data_d   = '0;
          out_tag_d    = tag_q;
          out_err_d    = 1'b1;
          state_d      = ST_IDLE;
        end
      end

      ST_PASS2: begin
        // Second half: the wrapped-around bits, shifted the opposite way by
        // (32 - n) mod 32. The 5-bit wrap makes n = 0 give data | data.
        // Assumes LEN_REG = 32 so the 5-bit amount covers the full word.
        w_sh_opecode = w_is_rol ? OPECODE_SHR : OPECODE_SHL;
        w_sh_data    = data_q;
        w_sh_amt     = 5'd0 - amt_q;
        out_valid_d  = 1'b1;
        out_data_d   = partial_q | sh_result;
        out_tag_d    = tag_q;
        out_err_d    = 1'b0;
        state_d      = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rr_q        <= 1'b0;
      op_q        <= '0;
      data_q      <= '0;
      amt_q       <= '0;
      tag_q       <= 1'b0;
      partial_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      op_q        <= op_d;
      data_q      <= data_d;
      amt_q       <= amt_d;
      tag_q       <= tag_d;
      partial_q   <= partial_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_tag_q   <= out_tag_d;
      out_err_q   <= out_err_d;
    end
  end

  // Handshake and shifter drive are held quiet while reset is asserted.
  assign in0_ready  = w_grant && !w_pick1 && !rst;
  assign in1_ready  = w_grant &&  w_pick1 && !rst;
  assign sh_opecode = rst ? '0 : w_sh_opecode;
  assign sh_data    = rst ? '0 : w_sh_data;
  assign sh_amt     = rst ? '0 : w_sh_amt;

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_tag    = out_tag_q;
  assign out_err    = out_err_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_shift_sched
// Purpose  : Self-checking bench for shift_sched with a behavioural shifter,
//            a transaction-level reference model and directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_sched;

  localparam logic [5:0] OP_SHL = 6'h10;
  localparam logic [5:0] OP_SHR = 6'h11;
  localparam logic [5:0] OP_ASH = 6'h12;
  localparam logic [5:0] OP_ROL = 6'h13;
  localparam logic [5:0] OP_ROR = 6'h14;
  localparam logic [5:0] OP_BAD = 6'h3F;

  logic        clk, rst;
  logic        in0_valid, in0_ready, in1_valid, in1_ready;
  logic [5:0]  in0_opecode, in1_opecode, sh_opecode;
  logic [31:0] in0_data, in1_data, sh_data, sh_result, out_data;
  logic [4:0]  in0_amt, in1_amt, sh_amt;
  logic        out_valid, out_ready, out_tag, out_err;

  int n_tests = 0;
  int n_fail  = 0;

  shift_sched #(
    .LEN_REG(32), .LEN_OPECODE(6),
    .OPECODE_SHL(OP_SHL), .OPECODE_SHR(OP_SHR), .OPECODE_ASH(OP_ASH),
    .OPECODE_ROL(OP_ROL), .OPECODE_ROR(OP_ROR)
  ) dut (
    .clk(clk), .rst(rst),
    .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_opecode(in0_opecode),
    .in0_data(in0_data), .in0_amt(in0_amt),
    .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_opecode(in1_opecode),
    .in1_data(in1_data), .in1_amt(in1_amt),
    .sh_opecode(sh_opecode), .sh_data(sh_data), .sh_amt(sh_amt),
    .sh_result(sh_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_err(out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural stand-in for the shared shifter.
  always_comb begin
    case (sh_opecode)
      OP_SHL:  sh_result = sh_data << sh_amt;
      OP_SHR:  sh_result = sh_data >> sh_amt;
      OP_ASH:  sh_result = 32'($signed(sh_data) >>> sh_amt);
      default: sh_result = 32'h0;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result of one request, computed from the op definition.
  function automatic logic [31:0] ref_result(input logic [5:0] op, input logic [31:0] d,
                                             input logic [4:0] n);
    logic [63:0] dd;
    dd = {d, d};
    case (op)
      OP_SHL:  return d << n;
      OP_SHR:  return d >> n;
      OP_ASH:  return 32'($signed(d) >>> n);
      OP_ROL:  begin dd = dd << n; return dd[63:32]; end
      OP_ROR:  begin dd = dd >> n; return dd[31:0]; end
      default: return 32'h0;
    endcase
  endfunction

  // ---------------- reference model + per-cycle compare -------------------
  // m_busy = cycles left until the in-flight op completes (0 = none).
  int          m_busy = 0;
  logic        m_rr   = 1'b0;
  logic [31:0] m_res  = '0;
  logic        m_tag  = 1'b0, m_err = 1'b0;
  logic        m_ov   = 1'b0, m_ot = 1'b0, m_oe = 1'b0;
  logic [31:0] m_od   = '0;

  always @(negedge clk) begin
    logic        slot, e0, e1;
    logic [5:0]  op;
    slot = (m_busy == 0) && (!m_ov || out_ready) && !rst;
    e0   = slot && in0_valid && (!in1_valid || !m_rr);
    e1   = slot && in1_valid && !e0;
    check("in0_ready", 32'(in0_ready), 32'(e0));
    check("in1_ready", 32'(in1_ready), 32'(e1));
    check("out_valid", 32'(out_valid), 32'(m_ov));
    if (m_ov) begin
      check("out_data", out_data, m_od);
      check("out_tag", 32'(out_tag), 32'(m_ot));
      check("out_err", 32'(out_err), 32'(m_oe));
    end
    if (rst) begin
      m_busy <= 0; m_rr <= 1'b0; m_ov <= 1'b0;
    end else begin
      if (m_busy == 1) begin
        m_ov <= 1'b1; m_od <= m_res; m_ot <= m_tag; m_oe <= m_err;
      end else if (m_ov && out_ready) begin
        m_ov <= 1'b0;
      end
      if (e0 || e1) begin
        op     = e1 ? in1_opecode : in0_opecode;
        m_res  <= e1 ? ref_result(in1_opecode, in1_data, in1_amt)
                     : ref_result(in0_opecode, in0_data, in0_amt);
        m_tag  <= e1;
        m_err  <= !(op inside {OP_SHL, OP_SHR, OP_ASH, OP_ROL, OP_ROR});
        m_busy <= (op == OP_ROL || op == OP_ROR) ? 2 : 1;
        m_rr   <= e0;
      end else if (m_busy != 0) begin
        m_busy <= m_busy - 1;
      end
    end
  end

  // ---------------- stimulus helpers --------------------------------------
  task automatic drive(input int port, input logic v, input logic [5:0] op,
                       input logic [31:0] d, input logic [4:0] a);
    if (port == 0) begin
      in0_valid = v; in0_opecode = op; in0_data = d; in0_amt = a;
    end else begin
      in1_valid = v; in1_opecode = op; in1_data = d; in1_amt = a;
    end
  endtask

  // Call just after a posedge; returns just after the accept edge.
  task automatic issue(input int port, input logic [5:0] op, input logic [31:0] d,
                       input logic [4:0] a);
    int k;
    logic rdy;
    drive(port, 1'b1, op, d, a);
    k = 0;
    do begin
      @(negedge clk);
      rdy = (port == 0) ? in0_ready : in1_ready;
      k++;
    end while (!rdy && k < 20);
    check("grant_seen", 32'(rdy), 32'd1);
    @(posedge clk); #1;
    drive(port, 1'b0, op, d, a);
  endtask

  // Counts negedges from after the accept edge until out_valid is seen.
  task automatic wait_out(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 20);
    check("out_valid_seen", 32'(out_valid), 32'd1);
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  // ---------------- directed sequence -------------------------------------
  initial begin
    int n;
    int gsel[4];
    int g, k;
    rst = 1'b1; out_ready = 1'b1;
    drive(0, 1'b1, OP_SHL, 32'h1, 5'd1);
    drive(1, 1'b0, 6'h0, 32'h0, 5'd0);
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_in0_ready", 32'(in0_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_out_tag", 32'(out_tag), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_sh_opecode", 32'(sh_opecode), 32'd0);
    check("rst_sh_data", sh_data, 32'h0);
    check("rst_sh_amt", 32'(sh_amt), 32'd0);
    next_cycle();
    rst = 1'b0; in0_valid = 1'b0;
    next_cycle();

    // Port0 SHL 1 by 31.
    issue(0, OP_SHL, 32'h0000_0001, 5'd31);
    wait_out(n);
    check("shl_latency", 32'(n), 32'd2);
    check("shl_data", out_data, 32'h8000_0000);
    check("shl_tag", 32'(out_tag), 32'd0);
    check("shl_err", 32'(out_err), 32'd0);
    next_cycle();

    // Port1 ASH, then ROL with the two-pass shifter sequence.
    issue(1, OP_ASH, 32'hF000_0000, 5'd4);
    wait_out(n);
    check("ash_data", out_data, 32'hFF00_0000);
    check("ash_tag", 32'(out_tag), 32'd1);
    next_cycle();
    issue(1, OP_ROL, 32'h8000_0001, 5'd4);
    @(negedge clk);
    check("rol_p1_op", 32'(sh_opecode), 32'(OP_SHL));
    check("rol_p1_amt", 32'(sh_amt), 32'd4);
    check("rol_p1_data", sh_data, 32'h8000_0001);
    @(negedge clk);
    check("rol_p2_op", 32'(sh_opecode), 32'(OP_SHR));
    check("rol_p2_amt", 32'(sh_amt), 32'd28);
    check("rol_p2_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("rol_valid", 32'(out_valid), 32'd1);
    check("rol_data", out_data, 32'h0000_0018);
    next_cycle();

    issue(0, OP_ROR, 32'h0000_0001, 5'd1);
    wait_out(n);
    check("ror_latency", 32'(n), 32'd3);
    check("ror_data", out_data, 32'h8000_0000);
    next_cycle();
    issue(1, OP_ROL, 32'h1234_5678, 5'd0);
    wait_out(n);
    check("rol0_data", out_data, 32'h1234_5678);
    next_cycle();

    // Both ports valid continuously: grants alternate starting with port0.
    drive(0, 1'b1, OP_SHL, 32'h11, 5'd1);
    drive(1, 1'b1, OP_SHR, 32'hF0, 5'd4);
    for (int i = 0; i < 4; i++) begin
      k = 0;
      do begin @(negedge clk); k++; end while (!(in0_ready || in1_ready) && k < 20);
      g = in1_ready ? 1 : 0;
      gsel[i] = g;
      next_cycle();
      if (g == 0) drive(0, 1'b1, OP_SHL, 32'h11 * (i + 2), 5'(i + 1));
      else        drive(1, 1'b1, OP_SHR, 32'hF0 << i, 5'd4);
    end
    in0_valid = 1'b0; in1_valid = 1'b0;
    for (int i = 0; i < 4; i++) check("rr_order", 32'(gsel[i]), 32'(i % 2));
    repeat (4) next_cycle();

    // Backpressure: result held, no grants while the slot is occupied.
    out_ready = 1'b0;
    issue(0, OP_SHL, 32'h0000_00A5, 5'd2);
    wait_out(n);
    next_cycle();
    drive(0, 1'b1, OP_SHR, 32'hFFFF_0000, 5'd8);
    drive(1, 1'b1, OP_ASH, 32'h8000_0000, 5'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_data", out_data, 32'h0000_0294);
      check("hold_tag", 32'(out_tag), 32'd0);
      check("hold_no_grant", 32'({in0_ready, in1_ready}), 32'd0);
    end
    next_cycle();
    out_ready = 1'b1;
    @(negedge clk);
    check("release_in1_ready", 32'(in1_ready), 32'd1);
    check("release_in0_ready", 32'(in0_ready), 32'd0);
    next_cycle();
    in1_valid = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while (!in0_ready && k < 20);
    check("pending_in0_grant", 32'(in0_ready), 32'd1);
    next_cycle();
    in0_valid = 1'b0;
    repeat (3) next_cycle();

    // Illegal opecode, then a legal op clears the error flag.
    issue(0, OP_BAD, 32'h0000_DEAD, 5'd3);
    wait_out(n);
    check("bad_data", out_data, 32'h0);
    check("bad_err", 32'(out_err), 32'd1);
    next_cycle();
    issue(1, OP_SHR, 32'h8000_0000, 5'd31);
    wait_out(n);
    check("after_bad_data", out_data, 32'h0000_0001);
    check("after_bad_err", 32'(out_err), 32'd0);
    next_cycle();

    // Reset while a ROL sits in its second pass.
    issue(0, OP_ROL, 32'h0000_0001, 5'd3);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_ready", 32'({in0_ready, in1_ready}), 32'd0);
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_mid_no_out", 32'(out_valid), 32'd0);
    end
    next_cycle();
    drive(0, 1'b1, OP_SHL, 32'h3, 5'd1);
    drive(1, 1'b1, OP_SHL, 32'h5, 5'd1);
    @(negedge clk);
    check("rst_rr_port0", 32'(in0_ready), 32'd1);
    check("rst_rr_not1", 32'(in1_ready), 32'd0);
    next_cycle();
    in0_valid = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while (!in1_ready && k < 20);
    check("post_rst_in1_grant", 32'(in1_ready), 32'd1);
    next_cycle();
    in1_valid = 1'b0;
    repeat (4) next_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
